arm_homing_sequencer: RTL

//  Bus master that homes one arm axis peripheral autonomously: programs divider, steps and

---
 rtl/arm_homing_sequencer_pkg.sv | 49 ++++
 rtl/arm_bus_master.sv | 82 ++++++++
 rtl/arm_homing_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/arm_homing_sequencer_pkg.sv
// Shared definitions for the arm axis homing sequencer: register map, control/status
// bit positions, error codes and state encodings.
package arm_homing_sequencer_pkg;

    localparam logic [7:0] REG_CTRL   = 8'd0;
    localparam logic [7:0] REG_STATUS = 8'd1;
    localparam logic [7:0] REG_DIV    = 8'd2;
    localparam logic [7:0] REG_STEPS  = 8'd3;

    localparam int CTRL_GO  = 7;
    localparam int CTRL_EN  = 6;
    localparam int CTRL_DIR = 5;
    localparam int CTRL_POL = 3;

    localparam int STAT_STEPPING = 0;
    localparam int STAT_FAULT    = 1;
    localparam int STAT_LIMIT    = 2;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_FAULT   = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_ABORT   = 3'd3,
        ERR_STUCK   = 3'd4
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_W_DIV, ST_W_STEPS, ST_W_CTRL, ST_SEEK_WAIT, ST_SEEK_RD,
        ST_W_BSTEPS, ST_W_BCTRL, ST_BACK_WAIT, ST_BACK_RD, ST_STOP, ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        BM_IDLE, BM_REQ, BM_SEL1, BM_SEL2, BM_SEL3, BM_END
    } bm_state_e;

    // Reserved bit 4 stays zero; enable is always set so the axis holds position when stopped.
    function automatic logic [31:0] ctrl_word(input logic go, input logic dir,
                                              input logic [2:0] microstep);
        logic [31:0] w;
        w           = '0;
        w[CTRL_GO]  = go;
        w[CTRL_EN]  = 1'b1;
        w[CTRL_DIR] = dir;
        w[CTRL_POL] = 1'b1;
        w[2:0]      = microstep;
        return w;
    endfunction

endpackage

// File: rtl/arm_bus_master.sv
// Register bus master: request/grant handshake followed by a fixed three-cycle select strobe.
module arm_bus_master
    import arm_homing_sequencer_pkg::*;
(
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_rw,
    input  logic [7:0]  op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_done,
    output logic [31:0] op_rdata,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [7:0]  register_addr,
    output logic        rw,
    output logic        select,
    inout  wire  [31:0] databus
);

    bm_state_e   state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q <= BM_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Once granted the strobe runs to completion; grant is not re-examined.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            BM_IDLE: begin
                if (op_start) begin
                    state_d = BM_REQ;
                    addr_d  = op_addr;
                    rw_d    = op_rw;
                    wdata_d = op_wdata;
                end
            end
            BM_REQ:  if (bus_grant) state_d = BM_SEL1;
            BM_SEL1: state_d = BM_SEL2;
            BM_SEL2: state_d = BM_SEL3;
            BM_SEL3: begin
                state_d = BM_END;
                if (rw_q) rdata_d = databus;
            end
            BM_END:  state_d = BM_IDLE;
            default: state_d = BM_IDLE;
        endcase
    end

    always_comb begin
        select  = (state_q == BM_SEL1) || (state_q == BM_SEL2) || (state_q == BM_SEL3);
        bus_req = select || (state_q == BM_REQ);
        op_done = (state_q == BM_END);
    end

    assign register_addr = addr_q;
    assign rw            = rw_q;
    assign op_rdata      = rdata_q;
    assign databus       = (select && !rw_q) ? wdata_q : 'z;

endmodule

// File: rtl/arm_homing_sequencer.sv
// Autonomous homing sequencer for one arm axis: seeks the limit switch, backs off a fixed
// step count and reports completion with an error code.
module arm_homing_sequencer
    import arm_homing_sequencer_pkg::*;
#(
    parameter logic [7:0]  AXIS_HADDR    = 8'd0,
    parameter logic        HOME_DIR      = 1'b0,
    parameter logic [2:0]  MICROSTEP     = 3'd0,
    parameter logic [31:0] HOME_DIV      = 32'd24000,
    parameter logic [31:0] BACKOFF_STEPS = 32'd200,
    parameter int unsigned POLL_CYCLES   = 12000,
    parameter logic [15:0] MAX_POLLS     = 16'd30000
)(
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [2:0]  error,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [7:0]  register_addr,
    output logic        rw,
    output logic        select,
    inout  wire  [31:0] databus
);

    localparam logic [31:0] WAIT_LAST = 32'(POLL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] poll_q, poll_d;
    logic [31:0] wait_q, wait_d;
    err_e        err_q, err_d;
    logic        abort_q, abort_d;
    logic        issued_q, issued_d;

    logic        op_start, op_rw, op_done;
    logic [7:0]  op_addr;
    logic [31:0] op_wdata, op_rdata;
    logic        abort_seen, st_fault, st_limit, st_stepping;
    logic [15:0] poll_inc;
    logic        unused_rdata_bits;

    assign abort_seen        = abort_q || abort;
    assign st_stepping       = op_rdata[STAT_STEPPING];
    assign st_fault          = op_rdata[STAT_FAULT];
    assign st_limit          = op_rdata[STAT_LIMIT];
    assign unused_rdata_bits = ^op_rdata[31:3];
    assign poll_inc          = poll_q + 16'd1;

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            poll_q   <= '0;
            wait_q   <= '0;
            err_q    <= ERR_OK;
            abort_q  <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            issued_q <= issued_d;
        end
    end

    // A pending abort is only honoured between transactions, so a strobe is never cut short.
    always_comb begin
        state_d  = state_q;
        poll_d   = poll_q;
        wait_d   = '0;
        err_d    = err_q;
        abort_d  = abort_q || (abort && busy);
        issued_d = (issued_q || op_start) && !op_done;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_W_DIV;
                    poll_d  = '0;
                    err_d   = ERR_OK;
                    abort_d = 1'b0;
                end
            end
            ST_W_DIV:    if (op_done) state_d = abort_seen ? ST_STOP : ST_W_STEPS;
            ST_W_STEPS:  if (op_done) state_d = abort_seen ? ST_STOP : ST_W_CTRL;
            ST_W_CTRL:   if (op_done) state_d = abort_seen ? ST_STOP : ST_SEEK_WAIT;
            ST_W_BSTEPS: if (op_done) state_d = abort_seen ? ST_STOP : ST_W_BCTRL;
            ST_W_BCTRL:  if (op_done) state_d = abort_seen ? ST_STOP : ST_BACK_WAIT;
            ST_SEEK_WAIT, ST_BACK_WAIT: begin
                if (abort_seen) begin
                    state_d = ST_STOP;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = (state_q == ST_SEEK_WAIT) ? ST_SEEK_RD : ST_BACK_RD;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_SEEK_RD: begin
                if (op_done) begin
                    if (abort_seen) begin
                        state_d = ST_STOP;
                    end else if (st_fault) begin
                        state_d = ST_STOP;
                        err_d   = ERR_FAULT;
                    end else if (st_limit) begin
                        state_d = ST_W_BSTEPS;
                        poll_d  = '0;
                    end else begin
                        poll_d = poll_inc;
                        if (poll_inc == MAX_POLLS) begin
                            state_d = ST_STOP;
                            err_d   = ERR_TIMEOUT;
                        end else begin
                            state_d = ST_SEEK_WAIT;
                        end
                    end
                end
            end
            ST_BACK_RD: begin
                if (op_done) begin
                    state_d = ST_STOP;
                    if (abort_seen) begin
                        state_d = ST_STOP;
                    end else if (st_fault) begin
                        err_d = ERR_FAULT;
                    end else if (st_stepping) begin
                        poll_d = poll_inc;
                        if (poll_inc == MAX_POLLS) err_d = ERR_TIMEOUT;
                        else state_d = ST_BACK_WAIT;
                    end else begin
                        err_d = st_limit ? ERR_STUCK : ERR_OK;
                    end
                end
            end
            ST_STOP:  if (op_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_seen && busy && state_q != ST_STOP && state_d == ST_STOP) err_d = ERR_ABORT;
        if (state_d == ST_STOP) abort_d = 1'b0;
    end

    always_comb begin
        busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done     = (state_q == ST_DONE);
        op_rw    = (state_q == ST_SEEK_RD) || (state_q == ST_BACK_RD);
        op_addr  = AXIS_HADDR + REG_CTRL;
        op_wdata = '0;
        op_start = !issued_q;
        case (state_q)
            ST_W_DIV:    begin op_addr = AXIS_HADDR + REG_DIV;   op_wdata = HOME_DIV; end
            ST_W_STEPS:  begin op_addr = AXIS_HADDR + REG_STEPS; op_wdata = 32'hFFFF_FFFF; end
            ST_W_CTRL:   op_wdata = ctrl_word(1'b1, HOME_DIR, MICROSTEP);
            ST_W_BSTEPS: begin op_addr = AXIS_HADDR + REG_STEPS; op_wdata = BACKOFF_STEPS; end
            ST_W_BCTRL:  op_wdata = ctrl_word(1'b1, ~HOME_DIR, MICROSTEP);
            ST_STOP:     op_wdata = ctrl_word(1'b0, HOME_DIR, MICROSTEP);
            ST_SEEK_RD, ST_BACK_RD: op_addr = AXIS_HADDR + REG_STATUS;
            default:     op_start = 1'b0;
        endcase
    end

    assign error = err_q;

    arm_bus_master u_bus_master (
        .clk_12MHz     (clk_12MHz),
        .reset         (reset),
        .op_start      (op_start),
        .op_rw         (op_rw),
        .op_addr       (op_addr),
        .op_wdata      (op_wdata),
        .op_done       (op_done),
        .op_rdata      (op_rdata),
        .bus_req       (bus_req),
        .bus_grant     (bus_grant),
        .register_addr (register_addr),
        .rw            (rw),
        .select        (select),
        .databus       (databus)
    );

endmodule
